// File: rtl/cascade_word_parser.sv
// cascade_word_parser
// Parses the Viola-Jones cascade ROM word stream. Stage and feature headers
// are consumed internally. Payload words go to one of three output channels
// (rect, feature threshold/leaf, stage threshold) through a single shared
// output register stage with downstream backpressure.
module cascade_word_parser #(
  parameter int DATA_W    = 32,
  parameter int MAX_RECTS = 3,
  parameter int RCNT_W    = 2,
  parameter int FCNT_W    = 12,
  parameter int STAGE_W   = 6
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [DATA_W-1:0]  rom_data_i,
  input  logic               rom_val_i,
  output logic               rom_rdy_o,
  input  logic               out_rdy_i,
  output logic [DATA_W-1:0]  rect_o,
  output logic               rect_part_o,
  output logic [RCNT_W-1:0]  rect_idx_o,
  output logic               rect_val_o,
  output logic [DATA_W-1:0]  thr_o,
  output logic [1:0]         thr_type_o,
  output logic               thr_val_o,
  output logic               feat_last_o,
  output logic [DATA_W-1:0]  stage_thr_o,
  output logic [STAGE_W-1:0] stage_idx_o,
  output logic               stage_thr_val_o,
  output logic               done_o,
  output logic               err_o
);

  // Rect word counter runs 0 .. 2*NR-1, so it needs one bit more than NR.
  localparam int CNT_W = RCNT_W + 1;

  localparam logic [3:0] S_HDR   = 4'd0;
  localparam logic [3:0] S_STHR  = 4'd1;
  localparam logic [3:0] F_HDR   = 4'd2;
  localparam logic [3:0] RECT    = 4'd3;
  localparam logic [3:0] F_THR   = 4'd4;
  localparam logic [3:0] F_LEFT  = 4'd5;
  localparam logic [3:0] F_RIGHT = 4'd6;
  localparam logic [3:0] S_DONE  = 4'd7;
  localparam logic [3:0] S_ERR   = 4'd8;

  logic [3:0]         state_reg, state_next;
  logic [FCNT_W-1:0]  feat_cnt_reg, feat_cnt_next;
  logic [RCNT_W-1:0]  nr_reg, nr_next;
  logic [CNT_W-1:0]   rect_cnt_reg, rect_cnt_next;
  logic [STAGE_W-1:0] stage_idx_reg, stage_idx_next;

  logic               out_pending;
  logic               halted;
  logic               accept;
  logic [FCNT_W-1:0]  nf_field;
  logic [RCNT_W-1:0]  nr_field;
  logic               last_rect;
  logic               last_feat;

  // Table of legal rect counts (1..MAX_RECTS) indexed by the header field;
  // avoids comparing a narrow field against a bound it may never reach.
  logic [(1<<RCNT_W)-1:0] nr_legal;

  genvar gi;
  generate
    for (gi = 0; gi < (1 << RCNT_W); gi++) begin : g_nr_legal
      localparam bit LEGAL = (gi >= 1) && (gi <= MAX_RECTS);
      assign nr_legal[gi] = LEGAL;
    end
  endgenerate

  assign out_pending = rect_val_o | thr_val_o | stage_thr_val_o;
  assign halted      = (state_reg == S_DONE) || (state_reg == S_ERR);
  // A start pulse blocks acceptance so the word in that cycle is not consumed.
  assign rom_rdy_o   = !halted && !start_i && (!out_pending || out_rdy_i);
  assign accept      = rom_val_i && rom_rdy_o;

  assign nf_field  = rom_data_i[FCNT_W-1:0];
  assign nr_field  = rom_data_i[RCNT_W-1:0];
  assign last_rect = (rect_cnt_reg == {nr_reg - RCNT_W'(1), 1'b1});
  assign last_feat = (feat_cnt_reg == FCNT_W'(1));

  assign done_o      = (state_reg == S_DONE);
  assign err_o       = (state_reg == S_ERR);
  assign stage_idx_o = stage_idx_reg;

  // Next-state and counter updates; everything advances only on an accepted word.
  always_comb begin
    state_next     = state_reg;
    feat_cnt_next  = feat_cnt_reg;
    nr_next        = nr_reg;
    rect_cnt_next  = rect_cnt_reg;
    stage_idx_next = stage_idx_reg;
    if (accept) begin
      case (state_reg)
        S_HDR: begin
          if (nf_field == '0) begin
            state_next = S_DONE;
          end else begin
            feat_cnt_next = nf_field;
            state_next    = S_STHR;
          end
        end
        S_STHR: state_next = F_HDR;
        F_HDR: begin
          if (!nr_legal[nr_field]) begin
            state_next = S_ERR;
          end else begin
            nr_next       = nr_field;
            rect_cnt_next = '0;
            state_next    = RECT;
          end
        end
        RECT: begin
          if (last_rect) begin
            rect_cnt_next = '0;
            state_next    = F_THR;
          end else begin
            rect_cnt_next = rect_cnt_reg + CNT_W'(1);
          end
        end
        F_THR:  state_next = F_LEFT;
        F_LEFT: state_next = F_RIGHT;
        F_RIGHT: begin
          feat_cnt_next = feat_cnt_reg - FCNT_W'(1);
          if (last_feat) begin
            // Stage index wraps silently.
            stage_idx_next = stage_idx_reg + STAGE_W'(1);
            state_next     = S_HDR;
          end else begin
            state_next = F_HDR;
          end
        end
        default: state_next = state_reg;
      endcase
    end
  end

  // Parser state registers; start restarts parsing exactly like reset.
  always_ff @(posedge clk_i) begin
    if (rst_i || start_i) begin
      state_reg     <= S_HDR;
      feat_cnt_reg  <= '0;
      nr_reg        <= '0;
      rect_cnt_reg  <= '0;
      stage_idx_reg <= '0;
    end else begin
      state_reg     <= state_next;
      feat_cnt_reg  <= feat_cnt_next;
      nr_reg        <= nr_next;
      rect_cnt_reg  <= rect_cnt_next;
      stage_idx_reg <= stage_idx_next;
    end
  end

  // Output register stage: load on accept, clear valids once taken, hold under backpressure.
  always_ff @(posedge clk_i) begin
    if (rst_i || start_i) begin
      rect_o          <= '0;
      rect_part_o     <= 1'b0;
      rect_idx_o      <= '0;
      rect_val_o      <= 1'b0;
      thr_o           <= '0;
      thr_type_o      <= 2'd0;
      thr_val_o       <= 1'b0;
      feat_last_o     <= 1'b0;
      stage_thr_o     <= '0;
      stage_thr_val_o <= 1'b0;
    end else if (accept) begin
      // Headers leave all valids low; accept already implies the old word left.
      rect_val_o      <= (state_reg == RECT);
      thr_val_o       <= (state_reg == F_THR) || (state_reg == F_LEFT) ||
                         (state_reg == F_RIGHT);
      stage_thr_val_o <= (state_reg == S_STHR);
      case (state_reg)
        S_STHR: stage_thr_o <= rom_data_i;
        RECT: begin
          rect_o      <= rom_data_i;
          rect_idx_o  <= rect_cnt_reg[CNT_W-1:1];
          rect_part_o <= rect_cnt_reg[0];
        end
        F_THR: begin
          thr_o       <= rom_data_i;
          thr_type_o  <= 2'd0;
          feat_last_o <= 1'b0;
        end
        F_LEFT: begin
          thr_o       <= rom_data_i;
          thr_type_o  <= 2'd1;
          feat_last_o <= 1'b0;
        end
        F_RIGHT: begin
          thr_o       <= rom_data_i;
          thr_type_o  <= 2'd2;
          feat_last_o <= last_feat;
        end
        default: ;
      endcase
    end else if (out_rdy_i) begin
      rect_val_o      <= 1'b0;
      thr_val_o       <= 1'b0;
      stage_thr_val_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cascade_word_parser.sv
// Directed bench for cascade_word_parser: hand-built word streams with
// hand-written expected output token lists, plus targeted timing checks.
module tb_cascade_word_parser;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] rom_data_i = '0;
  logic        rom_val_i = 1'b0;
  logic        rom_rdy_o;
  logic        out_rdy_i = 1'b0;
  logic [31:0] rect_o;
  logic        rect_part_o;
  logic [1:0]  rect_idx_o;
  logic        rect_val_o;
  logic [31:0] thr_o;
  logic [1:0]  thr_type_o;
  logic        thr_val_o;
  logic        feat_last_o;
  logic [31:0] stage_thr_o;
  logic [5:0]  stage_idx_o;
  logic        stage_thr_val_o;
  logic        done_o;
  logic        err_o;

  cascade_word_parser #(
    .DATA_W(32), .MAX_RECTS(3), .RCNT_W(2), .FCNT_W(12), .STAGE_W(6)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .rom_data_i(rom_data_i), .rom_val_i(rom_val_i), .rom_rdy_o(rom_rdy_o),
    .out_rdy_i(out_rdy_i),
    .rect_o(rect_o), .rect_part_o(rect_part_o), .rect_idx_o(rect_idx_o),
    .rect_val_o(rect_val_o),
    .thr_o(thr_o), .thr_type_o(thr_type_o), .thr_val_o(thr_val_o),
    .feat_last_o(feat_last_o),
    .stage_thr_o(stage_thr_o), .stage_idx_o(stage_idx_o),
    .stage_thr_val_o(stage_thr_val_o),
    .done_o(done_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic [31:0] words[$];
  logic [63:0] exp_q[$];
  logic [63:0] got_q[$];
  int          out_cyc_q[$];
  int          acc_cyc[512];

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Token: {channel, a, b, 0, data}. rect: a=idx b=part; thr: a=type b=last; stage: a=idx.
  function automatic logic [63:0] tok(input int ch, input int a, input int b, input logic [31:0] d);
    return {ch[7:0], a[7:0], b[7:0], 8'h00, d};
  endfunction

  task automatic ew(input logic [31:0] w); words.push_back(w); endtask
  task automatic er(input int i, input int p, input logic [31:0] d); exp_q.push_back(tok(1, i, p, d)); endtask
  task automatic et(input int t, input int l, input logic [31:0] d); exp_q.push_back(tok(2, t, l, d)); endtask
  task automatic es(input int i, input logic [31:0] d); exp_q.push_back(tok(3, i, 0, d)); endtask

  task automatic clear_all();
    words.delete(); exp_q.delete(); got_q.delete(); out_cyc_q.delete();
  endtask

  // Transfer monitor: one line per word taken downstream, plus one-hot valid check.
  always @(negedge clk_i) begin
    logic [63:0] t;
    check_eq("onehot", 64'($countones({rect_val_o, thr_val_o, stage_thr_val_o}) <= 1), 64'd1);
    if (!rst_i && !start_i && out_rdy_i && (rect_val_o || thr_val_o || stage_thr_val_o)) begin
      if (rect_val_o)     t = tok(1, int'(rect_idx_o), int'(rect_part_o), rect_o);
      else if (thr_val_o) t = tok(2, int'(thr_type_o), int'(feat_last_o), thr_o);
      else                t = tok(3, int'(stage_idx_o), 0, stage_thr_o);
      got_q.push_back(t);
      out_cyc_q.push_back(cyc);
      $display("xfer cyc=%0d ch=%0d a=%0d b=%0d data=%08h", cyc, t[63:56], t[55:48], t[47:40], t[31:0]);
    end
  end

  task automatic do_reset();
    @(posedge clk_i); #2;
    rst_i = 1'b1; start_i = 1'b0; rom_val_i = 1'b0; out_rdy_i = 1'b0; rom_data_i = '0;
    @(posedge clk_i); #2;
    rst_i = 1'b0;
    clear_all();
  endtask

  task automatic check_reset_state(input string tag);
    @(negedge clk_i);
    check_eq({tag, "_vals"}, 64'({rect_val_o, thr_val_o, stage_thr_val_o}), 64'd0);
    check_eq({tag, "_done_err"}, 64'({done_o, err_o}), 64'd0);
    check_eq({tag, "_rdy"}, 64'(rom_rdy_o), 64'd1);
    check_eq({tag, "_data"}, 64'(rect_o | thr_o | stage_thr_o), 64'd0);
    check_eq({tag, "_sidx"}, 64'(stage_idx_o), 64'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_i); #2;
      rom_val_i = 1'b0; out_rdy_i = 1'b1;
    end
  endtask

  // Presents words[] in order; returns on the negedge where the last word is accepted.
  task automatic feed(input int gap_pct, input bit rnd_rdy, input int stall_idx);
    int i = 0;
    int guard = 0;
    int n = words.size();
    logic [63:0] held;
    while (i < n) begin
      @(posedge clk_i); #2;
      out_rdy_i = rnd_rdy ? ($urandom_range(0, 99) < 50) : 1'b1;
      if (i == stall_idx) begin
        out_rdy_i = 1'b0; rom_val_i = 1'b1; rom_data_i = words[i];
        for (int k = 0; k < 5; k++) begin
          @(negedge clk_i);
          if (k == 0) begin
            held = 64'({rect_val_o, rect_part_o, rect_idx_o, rect_o});
            check_eq("stall_pending", 64'(rect_val_o), 64'd1);
          end
          check_eq("stall_rdy", 64'(rom_rdy_o), 64'd0);
          @(posedge clk_i); #2;
        end
        check_eq("stall_hold", 64'({rect_val_o, rect_part_o, rect_idx_o, rect_o}), held);
        out_rdy_i = 1'b1;
      end
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        rom_val_i = 1'b0; rom_data_i = 32'hDEAD_BEEF;
      end else begin
        rom_val_i = 1'b1; rom_data_i = words[i];
      end
      @(negedge clk_i);
      if (rom_val_i && rom_rdy_o) begin
        acc_cyc[i] = cyc;
        i++;
      end
      guard++;
      if (guard > 4000) begin
        check_eq("feed_timeout", 64'(i), 64'(n));
        break;
      end
    end
  endtask

  task automatic compare_stream(input string tag);
    int n;
    check_eq({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check_eq($sformatf("%s_tok%0d", tag, i), got_q[i], exp_q[i]);
  endtask

  // One stage, NF=1, NR=2, then end-of-cascade header.
  task automatic build_t1();
    ew(32'h1); ew(32'hA0); ew(32'h2);
    ew(32'h100); ew(32'h101); ew(32'h102); ew(32'h103);
    ew(32'h200); ew(32'h201); ew(32'h202); ew(32'h0);
    es(0, 32'hA0);
    er(0, 0, 32'h100); er(0, 1, 32'h101); er(1, 0, 32'h102); er(1, 1, 32'h103);
    et(0, 0, 32'h200); et(1, 0, 32'h201); et(2, 1, 32'h202);
  endtask

  // Full stage 0 (NF=1, NR=1) then stage 1 stopped partway through its rects.
  task automatic build_prefix();
    ew(32'h1); ew(32'hF0); ew(32'h1); ew(32'h600); ew(32'h601);
    ew(32'h610); ew(32'h611); ew(32'h612);
    ew(32'h1); ew(32'hF1); ew(32'h2); ew(32'h620); ew(32'h621);
  endtask

  task automatic add_feat(input logic [31:0] base, input int last);
    ew(32'h1); ew(base); ew(base + 1);
    ew(base + 32'h10); ew(base + 32'h11); ew(base + 32'h12);
    er(0, 0, base); er(0, 1, base + 1);
    et(0, 0, base + 32'h10); et(1, 0, base + 32'h11); et(2, last, base + 32'h12);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: cycle=%0d limit reached", cyc);
    $fatal(1, "global timeout");
  end

  initial begin
    // Reset state
    do_reset();
    check_reset_state("reset");

    // T1: basic stream with continuous valid/ready
    build_t1();
    feed(0, 1'b0, -1);
    @(negedge clk_i);
    check_eq("t1_done", 64'(done_o), 64'd1);
    check_eq("t1_rdy_after_done", 64'(rom_rdy_o), 64'd0);
    idle(3);
    compare_stream("t1");
    if (out_cyc_q.size() > 0) check_eq("t1_sthr_latency", 64'(out_cyc_q[0] - acc_cyc[1]), 64'd1);
    else check_eq("t1_sthr_seen", 64'(out_cyc_q.size()), 64'd1);

    // T3: same stream, downstream stalls 5 cycles while rect (0,1) is pending
    do_reset();
    build_t1();
    feed(0, 1'b0, 5);
    @(negedge clk_i);
    check_eq("t3_done", 64'(done_o), 64'd1);
    idle(3);
    compare_stream("t3");

    // T2: NR=3 feature, then a header whose NR field reads 0 (word 0x4) -> error
    do_reset();
    ew(32'h1); ew(32'hB0); ew(32'h3);
    for (int k = 0; k < 6; k++) ew(32'h300 + 32'(k));
    ew(32'h310); ew(32'h311); ew(32'h312);
    ew(32'h1); ew(32'hB1); ew(32'h4);
    es(0, 32'hB0);
    er(0, 0, 32'h300); er(0, 1, 32'h301); er(1, 0, 32'h302);
    er(1, 1, 32'h303); er(2, 0, 32'h304); er(2, 1, 32'h305);
    et(0, 0, 32'h310); et(1, 0, 32'h311); et(2, 1, 32'h312);
    es(1, 32'hB1);
    feed(0, 1'b0, -1);
    @(negedge clk_i);
    check_eq("t2_err", 64'(err_o), 64'd1);
    check_eq("t2_rdy", 64'(rom_rdy_o), 64'd0);
    repeat (5) begin
      @(posedge clk_i); #2;
      rom_val_i = 1'b1; rom_data_i = 32'h7; out_rdy_i = 1'b1;
    end
    @(negedge clk_i);
    check_eq("t2_err_sticky", 64'({err_o, done_o, rom_rdy_o}), 64'b100);
    compare_stream("t2");

    // T2b: start clears the error; NR=0 header errors again, stage index back at 0
    @(posedge clk_i); #2;
    start_i = 1'b1; rom_val_i = 1'b0;
    @(posedge clk_i); #2;
    start_i = 1'b0;
    clear_all();
    ew(32'h1); ew(32'hC0); ew(32'h0);
    es(0, 32'hC0);
    feed(0, 1'b0, -1);
    @(negedge clk_i);
    check_eq("t2b_err", 64'(err_o), 64'd1);
    idle(3);
    compare_stream("t2b");

    // T4: two stages of NF=2 with random valid gaps and random downstream ready
    do_reset();
    ew(32'h2); ew(32'hD0); es(0, 32'hD0);
    add_feat(32'h400, 0); add_feat(32'h420, 1);
    ew(32'h2); ew(32'hD1); es(1, 32'hD1);
    add_feat(32'h440, 0); add_feat(32'h460, 1);
    ew(32'h0);
    feed(50, 1'b1, -1);
    @(negedge clk_i);
    check_eq("t4_done", 64'(done_o), 64'd1);
    idle(10);
    compare_stream("t4");

    // T5: start during stage 1 rects with an output pending
    do_reset();
    build_prefix();
    feed(0, 1'b0, -1);
    @(posedge clk_i); #2;
    start_i = 1'b1; out_rdy_i = 1'b0; rom_val_i = 1'b1; rom_data_i = 32'h5;
    @(negedge clk_i);
    check_eq("t5_rdy_in_start", 64'(rom_rdy_o), 64'd0);
    check_eq("t5_pending_before", 64'(rect_val_o), 64'd1);
    check_eq("t5_sidx_before", 64'(stage_idx_o), 64'd1);
    @(posedge clk_i); #2;
    start_i = 1'b0; rom_val_i = 1'b0; out_rdy_i = 1'b1;
    @(negedge clk_i);
    check_eq("t5_dropped", 64'(rect_val_o), 64'd0);
    check_eq("t5_sidx_after", 64'(stage_idx_o), 64'd0);
    clear_all();
    ew(32'h1); ew(32'hE0); ew(32'h1); ew(32'h500); ew(32'h501);
    ew(32'h510); ew(32'h511); ew(32'h512); ew(32'h0);
    es(0, 32'hE0); er(0, 0, 32'h500); er(0, 1, 32'h501);
    et(0, 0, 32'h510); et(1, 0, 32'h511); et(2, 1, 32'h512);
    feed(0, 1'b0, -1);
    @(negedge clk_i);
    check_eq("t5_done", 64'(done_o), 64'd1);
    idle(3);
    compare_stream("t5");

    // T5b: same situation, interrupted by rst_i instead
    do_reset();
    build_prefix();
    feed(0, 1'b0, -1);
    @(posedge clk_i); #2;
    rst_i = 1'b1; out_rdy_i = 1'b0; rom_val_i = 1'b1; rom_data_i = 32'h5;
    @(posedge clk_i); #2;
    rst_i = 1'b0; rom_val_i = 1'b0;
    check_reset_state("t5b");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
